// File: rtl/nice_chain_pkg.sv
// Shared types and constants for the chained-sequencer link: FSM state
// encodings for both directions and the error counter width.
package nice_chain_pkg;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } seg_state_e;

  typedef enum logic [1:0] {
    R_COLLECT,
    R_HOLD,
    R_DROP
  } rsm_state_e;

  localparam int ERR_CNT_W = 8;

  // Saturating increment: the error counter sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nice_chain_link_if.sv
// Bundle of all handshake, data and error signals of one chain link, plus the
// state of both FSMs for observation. "slave" is the link's view, "master" the environment's.
interface nice_chain_link_if #(
  parameter int UP_W = 64,
  parameter int DN_W = 16
) ();
  import nice_chain_pkg::*;

  // Every channel: a beat/word moves on a rising edge where valid && ready;
  // valid, once high, holds with stable data until that edge.
  logic                 up_req_valid;
  logic                 up_req_ready;
  logic [UP_W-1:0]      up_req_data;
  logic                 dn_req_valid;
  logic                 dn_req_ready;
  logic [DN_W-1:0]      dn_req_data;
  logic                 dn_req_last;
  logic                 dn_trf_valid;
  logic                 dn_trf_ready;
  logic [DN_W-1:0]      dn_trf_data;
  logic                 dn_trf_last;
  logic                 up_trf_valid;
  logic                 up_trf_ready;
  logic [UP_W-1:0]      up_trf_data;
  logic                 err_short;
  logic                 err_long;
  logic [ERR_CNT_W-1:0] err_cnt;
  seg_state_e           seg_state;
  rsm_state_e           rsm_state;

  modport slave (
    input  up_req_valid, up_req_data, dn_req_ready,
    input  dn_trf_valid, dn_trf_data, dn_trf_last, up_trf_ready,
    output up_req_ready, dn_req_valid, dn_req_data, dn_req_last,
    output dn_trf_ready, up_trf_valid, up_trf_data,
    output err_short, err_long, err_cnt, seg_state, rsm_state
  );

  modport master (
    output up_req_valid, up_req_data, dn_req_ready,
    output dn_trf_valid, dn_trf_data, dn_trf_last, up_trf_ready,
    input  up_req_ready, dn_req_valid, dn_req_data, dn_req_last,
    input  dn_trf_ready, up_trf_valid, up_trf_data,
    input  err_short, err_long, err_cnt, seg_state, rsm_state
  );

endinterface

// File: rtl/nice_chain_reassembler.sv
// Traffic path: packs downstream beats into upstream words, checks framing
// against the sender's last marker and counts framing errors.
module nice_chain_reassembler
  import nice_chain_pkg::*;
#(
  parameter int UP_W = 64,
  parameter int DN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dn_trf_valid,
  input  logic [DN_W-1:0]      dn_trf_data,
  input  logic                 dn_trf_last,
  output logic                 dn_trf_ready,
  output logic                 up_trf_valid,
  output logic [UP_W-1:0]      up_trf_data,
  input  logic                 up_trf_ready,
  output logic                 err_short,
  output logic                 err_long,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output rsm_state_e           state_dbg
);

  localparam int RATIO = UP_W / DN_W;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

  rsm_state_e           rsm_state_q, rsm_state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [UP_W-1:0]      data_buf_q, data_buf_d;
  logic                 drop_pend_q, drop_pend_d;
  logic                 err_short_q, err_short_d;
  logic                 err_long_q, err_long_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rsm_state_d = rsm_state_q;
    cnt_d       = cnt_q;
    data_buf_d  = data_buf_q;
    drop_pend_d = drop_pend_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    dn_trf_ready = (rsm_state_q == R_HOLD) ? up_trf_ready : 1'b1;

    // Leaving HOLD frees the buffer, so a beat in the same cycle lands in slot 0.
    if (rsm_state_q == R_HOLD && up_trf_ready) begin
      rsm_state_d = drop_pend_q ? R_DROP : R_COLLECT;
      drop_pend_d = 1'b0;
    end

    if (dn_trf_valid && dn_trf_ready) begin
      if (rsm_state_d == R_DROP) begin
        if (dn_trf_last) begin
          rsm_state_d = R_COLLECT;
          cnt_d       = '0;
        end
      end else begin
        data_buf_d[cnt_q*DN_W +: DN_W] = dn_trf_data;
        if (cnt_q == LAST_SLOT) begin
          rsm_state_d = R_HOLD;
          cnt_d       = '0;
          if (!dn_trf_last) begin
            err_long_d  = 1'b1;
            drop_pend_d = 1'b1;
          end
        end else if (dn_trf_last) begin
          err_short_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    err_cnt_d = (err_short_d || err_long_d) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsm_state_q <= R_COLLECT;
      cnt_q       <= '0;
      data_buf_q  <= '0;
      drop_pend_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rsm_state_q <= rsm_state_d;
      cnt_q       <= cnt_d;
      data_buf_q  <= data_buf_d;
      drop_pend_q <= drop_pend_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign up_trf_valid = (rsm_state_q == R_HOLD);
  assign up_trf_data  = data_buf_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign err_cnt      = err_cnt_q;
  assign state_dbg    = rsm_state_q;

endmodule

// File: rtl/nice_chain_link.sv
// One chain link: splits request words into LSB-first beats (segmenter inline)
// and hands the traffic direction to the reassembler sub-module.
module nice_chain_link
  import nice_chain_pkg::*;
#(
  parameter int UP_W = 64,
  parameter int DN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  nice_chain_link_if.slave bus
);

  localparam int RATIO = UP_W / DN_W;
  localparam int BW    = $clog2(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  seg_state_e      seg_state_q, seg_state_d;
  logic [UP_W-1:0] word_q, word_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            dn_fire;
  logic            up_ready;

  always_comb begin
    seg_state_d = seg_state_q;
    word_d      = word_q;
    beat_d      = beat_q;
    dn_fire     = (seg_state_q == S_SEND) && bus.dn_req_ready;
    // Ready also opens on the final beat's transfer so words stream without a bubble.
    up_ready    = (seg_state_q == S_IDLE) || (dn_fire && beat_q == LAST_BEAT);

    if (dn_fire) begin
      if (beat_q == LAST_BEAT) seg_state_d = S_IDLE;
      else                     beat_d      = beat_q + 1'b1;
    end

    if (up_ready && bus.up_req_valid) begin
      word_d      = bus.up_req_data;
      beat_d      = '0;
      seg_state_d = S_SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_state_q <= S_IDLE;
      word_q      <= '0;
      beat_q      <= '0;
    end else begin
      seg_state_q <= seg_state_d;
      word_q      <= word_d;
      beat_q      <= beat_d;
    end
  end

  assign bus.up_req_ready = up_ready;
  assign bus.dn_req_valid = (seg_state_q == S_SEND);
  assign bus.dn_req_data  = word_q[beat_q*DN_W +: DN_W];
  assign bus.dn_req_last  = (seg_state_q == S_SEND) && (beat_q == LAST_BEAT);
  assign bus.seg_state    = seg_state_q;

  nice_chain_reassembler #(
    .UP_W (UP_W),
    .DN_W (DN_W)
  ) u_rsm (
    .clk          (clk),
    .rst          (rst),
    .dn_trf_valid (bus.dn_trf_valid),
    .dn_trf_data  (bus.dn_trf_data),
    .dn_trf_last  (bus.dn_trf_last),
    .dn_trf_ready (bus.dn_trf_ready),
    .up_trf_valid (bus.up_trf_valid),
    .up_trf_data  (bus.up_trf_data),
    .up_trf_ready (bus.up_trf_ready),
    .err_short    (bus.err_short),
    .err_long     (bus.err_long),
    .err_cnt      (bus.err_cnt),
    .state_dbg    (bus.rsm_state)
  );

endmodule

// File: tb/tb_nice_chain_link.sv
// Bench for nice_chain_link: directed scenarios then random traffic, checked
// every cycle against a beat/frame-level reference model.
module tb_nice_chain_link;

  localparam int UP_W  = 64;
  localparam int DN_W  = 16;
  localparam int RATIO = UP_W / DN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nice_chain_link_if #(.UP_W(UP_W), .DN_W(DN_W)) bus ();

  nice_chain_link #(.UP_W(UP_W), .DN_W(DN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [DN_W:0]   exp_beat_q[$];   // {last, data} expected on dn_req
  logic [UP_W-1:0] exp_q[$];        // words expected on up_trf
  logic [DN_W-1:0] frame_q[$];      // beats of the frame being received
  logic [DN_W-1:0] got_q[$];        // dn_req beats actually seen
  logic [UP_W-1:0] src_w[$];        // words waiting to be offered upstream
  logic [DN_W:0]   src_t[$];        // {last, data} beats waiting to be offered downstream
  bit              dropping = 0;
  bit              exp_short = 0;
  bit              exp_long = 0;
  int              model_cnt = 0;
  bit              stall_chk = 0;
  logic [DN_W-1:0] held_beat = '0;
  bit              up_x, dn_x, trf_x, upt_x;
  int              dn_mode = 0;     // 0 high, 1 toggle, 2 random, 3 low
  int              ut_mode = 0;
  int              gap_pct = 0;

  function automatic void chk(string tag, logic [UP_W-1:0] obs, logic [UP_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // ---------------- model + checks, sampled at negedge ----------------
  task automatic sample();
    logic [UP_W-1:0] w;
    @(negedge clk);
    // request direction
    chk("up_req_ready", bus.up_req_ready,
        (exp_beat_q.size() == 0) || (exp_beat_q.size() == 1 && bus.dn_req_ready));
    chk("dn_req_valid", bus.dn_req_valid, exp_beat_q.size() != 0);
    if (bus.dn_req_valid && exp_beat_q.size() != 0) begin
      chk("dn_req_data", bus.dn_req_data, exp_beat_q[0][DN_W-1:0]);
      chk("dn_req_last", bus.dn_req_last, exp_beat_q[0][DN_W]);
    end
    if (stall_chk) chk("dn_req_stable", bus.dn_req_data, held_beat);
    stall_chk = bus.dn_req_valid && !bus.dn_req_ready;
    held_beat = bus.dn_req_data;
    dn_x = bus.dn_req_valid && bus.dn_req_ready;
    up_x = bus.up_req_valid && bus.up_req_ready;
    if (dn_x) begin
      got_q.push_back(bus.dn_req_data);
      if (exp_beat_q.size() != 0) void'(exp_beat_q.pop_front());
    end
    if (up_x)
      for (int i = 0; i < RATIO; i++)
        exp_beat_q.push_back({i == RATIO - 1, DN_W'(bus.up_req_data >> (i * DN_W))});

    // traffic direction
    chk("err_short", bus.err_short, exp_short);
    chk("err_long", bus.err_long, exp_long);
    chk("err_cnt", bus.err_cnt, model_cnt);
    chk("up_trf_valid", bus.up_trf_valid, exp_q.size() != 0);
    chk("dn_trf_ready", bus.dn_trf_ready, (exp_q.size() == 0) || bus.up_trf_ready);
    if (bus.up_trf_valid && exp_q.size() != 0) chk("up_trf_data", bus.up_trf_data, exp_q[0]);
    exp_short = 0;
    exp_long  = 0;
    upt_x = bus.up_trf_valid && bus.up_trf_ready;
    trf_x = bus.dn_trf_valid && bus.dn_trf_ready;
    if (upt_x && exp_q.size() != 0) void'(exp_q.pop_front());
    if (trf_x) begin
      if (dropping) begin
        if (bus.dn_trf_last) dropping = 0;
      end else begin
        frame_q.push_back(bus.dn_trf_data);
        if (frame_q.size() == RATIO) begin
          w = '0;
          for (int i = 0; i < RATIO; i++) w = w | (UP_W'(frame_q[i]) << (i * DN_W));
          exp_q.push_back(w);
          frame_q.delete();
          if (!bus.dn_trf_last) begin
            exp_long = 1;
            dropping = 1;
            if (model_cnt < 255) model_cnt++;
          end
        end else if (bus.dn_trf_last) begin
          exp_short = 1;
          frame_q.delete();
          if (model_cnt < 255) model_cnt++;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    if (up_x) bus.up_req_valid = 1'b0;
    if (!bus.up_req_valid && src_w.size() != 0 && $urandom_range(99) >= gap_pct) begin
      bus.up_req_valid = 1'b1;
      bus.up_req_data  = src_w.pop_front();
    end
    if (trf_x) bus.dn_trf_valid = 1'b0;
    if (!bus.dn_trf_valid && src_t.size() != 0 && $urandom_range(99) >= gap_pct) begin
      logic [DN_W:0] b;
      b = src_t.pop_front();
      bus.dn_trf_valid = 1'b1;
      bus.dn_trf_last  = b[DN_W];
      bus.dn_trf_data  = b[DN_W-1:0];
    end
    case (dn_mode)
      0: bus.dn_req_ready = 1'b1;
      1: bus.dn_req_ready = !bus.dn_req_ready;
      2: bus.dn_req_ready = 1'($urandom_range(1));
      default: bus.dn_req_ready = 1'b0;
    endcase
    case (ut_mode)
      0: bus.up_trf_ready = 1'b1;
      1: bus.up_trf_ready = !bus.up_trf_ready;
      2: bus.up_trf_ready = 1'($urandom_range(1));
      default: bus.up_trf_ready = 1'b0;
    endcase
  endtask

  task automatic tick();
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy();
    return src_w.size() != 0 || src_t.size() != 0 || bus.up_req_valid || bus.dn_trf_valid ||
           exp_beat_q.size() != 0 || exp_q.size() != 0;
  endfunction

  task automatic run_idle(input int max_cycles);
    int n = 0;
    while (busy() && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drain_in_time", n < max_cycles, 1'b1);
  endtask

  task automatic push_frame(input int len);
    for (int i = 0; i < len; i++) src_t.push_back({i == len - 1, 16'($urandom)});
  endtask

  task automatic do_reset();
    bus.up_req_valid = 1'b0;
    bus.dn_trf_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_beat_q.delete(); exp_q.delete(); frame_q.delete();
    src_w.delete(); src_t.delete();
    dropping = 0; exp_short = 0; exp_long = 0; model_cnt = 0;
    stall_chk = 0; up_x = 0; dn_x = 0; trf_x = 0; upt_x = 0;
    chk("rst_up_req_ready", bus.up_req_ready, 1'b1);
    chk("rst_dn_trf_ready", bus.dn_trf_ready, 1'b1);
    chk("rst_dn_req_valid", bus.dn_req_valid, 1'b0);
    chk("rst_up_trf_valid", bus.up_trf_valid, 1'b0);
    chk("rst_err_pulses", {bus.err_short, bus.err_long}, 2'b00);
    chk("rst_err_cnt", bus.err_cnt, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DN_W-1:0] e1[4];
    int n;
    e1 = '{16'h7788, 16'h5566, 16'h3344, 16'h1122};
    bus.up_req_valid = 1'b0; bus.up_req_data = '0;
    bus.dn_req_ready = 1'b1;
    bus.dn_trf_valid = 1'b0; bus.dn_trf_data = '0; bus.dn_trf_last = 1'b0;
    bus.up_trf_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // one word, always-ready downstream
    got_q.delete();
    src_w.push_back(64'h1122_3344_5566_7788);
    run_idle(50);
    chk("one_word_beats", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("one_word_beat", got_q[i], e1[i]);

    // back-to-back words: 8 beats within the 9 cycles starting at the first accept
    got_q.delete();
    src_w.push_back(64'h0123_4567_89AB_CDEF);
    src_w.push_back(64'hFEDC_BA98_7654_3210);
    tick();
    repeat (9) tick();
    chk("b2b_beats", got_q.size(), 8);
    run_idle(50);

    // downstream backpressure 1,0,1,0...
    dn_mode = 1;
    src_w.push_back(64'hCAFE_F00D_DEAD_BEEF);
    run_idle(50);
    dn_mode = 0;

    // reassembly with upstream stalled for 5 cycles, second frame waiting behind
    ut_mode = 3;
    src_t.push_back({1'b0, 16'hAAAA});
    src_t.push_back({1'b0, 16'hBBBB});
    src_t.push_back({1'b0, 16'hCCCC});
    src_t.push_back({1'b1, 16'hDDDD});
    push_frame(4);
    n = 0;
    while (!bus.up_trf_valid && n < 20) begin tick(); n++; end
    chk("hold_reached", bus.up_trf_valid, 1'b1);
    repeat (5) begin
      tick();
      chk("stall_word", bus.up_trf_data, 64'hDDDD_CCCC_BBBB_AAAA);
      chk("stall_dn_ready", bus.dn_trf_ready, 1'b0);
    end
    ut_mode = 0;
    run_idle(50);

    // short frame then a good one
    push_frame(2);
    push_frame(4);
    run_idle(50);
    chk("short_err_cnt", bus.err_cnt, 8'd1);

    // long frame: first 4 delivered, rest dropped
    push_frame(6);
    push_frame(4);
    run_idle(50);
    chk("long_err_cnt", bus.err_cnt, 8'd2);

    // reset mid-frame and mid-word
    src_t.push_back({1'b0, 16'h1111});
    src_t.push_back({1'b0, 16'h2222});
    src_w.push_back(64'h5555_6666_7777_8888);
    repeat (4) tick();
    do_reset();
    push_frame(4);
    src_w.push_back(64'h9999_AAAA_BBBB_CCCC);
    run_idle(50);
    chk("post_rst_err_cnt", bus.err_cnt, 8'd0);

    // error counter saturation
    for (int i = 0; i < 260; i++) push_frame(1);
    run_idle(2000);
    chk("err_cnt_sat", bus.err_cnt, 8'd255);
    do_reset();

    // random traffic in both directions
    dn_mode = 2;
    ut_mode = 2;
    gap_pct = 30;
    for (int i = 0; i < 200; i++) src_w.push_back({$urandom, $urandom});
    for (int i = 0; i < 200; i++) push_frame($urandom_range(7, 1));
    run_idle(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nice_chain_link.md
# nice_chain_link

Hardware counterpart of one link in a chained-sequencer stack; it sits directly downstream of a chained sequencer's driver. It converts upstream request words into a stream of narrower downstream beats (segmentation). In the other direction, it reassembles downstream traffic beats into upstream words (reassembly) and flags framing errors. Each direction is independent and uses valid/ready handshakes.

## Interface
- UP_W, 64, upstream word width; must be an integer multiple of DN_W.
- DN_W, 16, downstream beat width.
- RATIO, UP_W/DN_W (derived localparam, ≥2), beats per word.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous and active-high.
- up_req_valid / up_req_ready  in / out  1  upstream request handshake.
- up_req_data  in  UP_W  request word.
- dn_req_valid / dn_req_ready  out / in  1  downstream request handshake.
- dn_req_data  out  DN_W  request beat.
- dn_req_last  out  1  final beat of a word.
- dn_trf_valid / dn_trf_ready  in / out  1  downstream traffic handshake.
- dn_trf_data  in  DN_W  traffic beat.
- dn_trf_last  in  1  sender's end-of-frame marker.
- up_trf_valid / up_trf_ready  out / in  1  upstream traffic handshake.
- up_trf_data  out  UP_W  reassembled word.
- err_short  out  1  one-cycle pulse: frame ended before RATIO beats.
- err_long  out  1  one-cycle pulse: RATIO beats received without last.
- err_cnt  out  8  saturating count of err_short and err_long events.

## Operation
- Handshake: a transfer occurs when valid && ready on a clock edge.
- Valid, once asserted, is held with stable data until the transfer occurs.
- Segmenter FSM, states S_IDLE and S_SEND:
  - S_IDLE: up_req_ready=1. On transfer, latch the word, set beat=0, go to S_SEND.
  - S_SEND: dn_req_valid=1. dn_req_data = word[beat*DN_W +: DN_W], LSB slice first. dn_req_last = (beat==RATIO-1).
  - On a dn transfer with beat<RATIO-1: beat++.
  - On a dn transfer with beat==RATIO-1: up_req_ready=1 combinationally in that cycle. If a new word transfers in the same cycle, reload it and stay in S_SEND with beat=0. Otherwise go to S_IDLE.
- Reassembler FSM, states R_COLLECT, R_HOLD and R_DROP:
  - R_COLLECT: dn_trf_ready=1. Each beat is written to buf[cnt*DN_W +: DN_W], then cnt++.
  - Last with cnt<RATIO-1: pulse err_short, discard the partial word, cnt=0.
  - Beat RATIO-1 with last: go to R_HOLD.
  - Beat RATIO-1 without last: pulse err_long, go to R_HOLD, and go on to R_DROP after the word is delivered.
  - R_HOLD: up_trf_valid=1, up_trf_data=buf, dn_trf_ready = up_trf_ready (pass-through). When the up transfer occurs, move to the next state. The next state is R_COLLECT, or R_DROP when a drop is pending. In the same cycle the next beat may be accepted into slot 0.
  - R_DROP: dn_trf_ready=1. Beats are consumed and discarded. The beat carrying last returns the FSM to R_COLLECT with cnt=0. Dropped beats raise no further error pulses.
- err_cnt increments by 1 per error pulse and saturates at 255. err_short and err_long are never asserted in the same cycle.

## Timing
- Reset values:
  - Both FSMs return to their initial states: S_IDLE and R_COLLECT.
  - beat=0, cnt=0, err_cnt=0.
  - All valid outputs and err pulses are 0.
  - up_req_ready=1 and dn_trf_ready=1 in the first cycle after reset.
  - Data outputs are don't-care but must not be X-propagating: registers reset to 0.
- Request latency: word accepted at edge N → first beat valid from cycle N+1.
  - Sustained throughput is RATIO beats per RATIO cycles with no idle bubble between words.
- Traffic latency: last beat accepted at edge N → up_trf_valid in cycle N+1.
  - Sustained throughput is one word per RATIO cycles when up_trf_ready=1.
- Error pulses are registered and appear in the cycle after the offending beat's transfer.
- Reset mid-operation:
  - The in-flight word or partial frame is dropped and no error is reported.
  - Downstream must not treat deassertion of dn_req_valid on reset as a protocol error.

## Structure
- Package nice_chain_pkg holds:
  - seg_state_e {S_IDLE, S_SEND} and rsm_state_e {R_COLLECT, R_HOLD, R_DROP}.
  - ERR_CNT_W=8.
- Sub-module nice_chain_reassembler holds the traffic path and error counting.
- The segmenter stays inline in nice_chain_link.

## Test plan
All scenarios use UP_W=64, DN_W=16.
- Segment one word: 0x1122_3344_5566_7788 with dn_req_ready=1 → beats 0x7788, 0x5566, 0x3344, 0x1122 on consecutive cycles, last only on the 4th.
- Back-to-back words with dn_req_ready always high → 8 beats in 8 consecutive cycles. up_req_ready is high in the 4th-beat cycle.
- Downstream backpressure: dn_req_ready toggles 1,0,1,0… → beat data stays stable while stalled. All 4 beats arrive in order.
- Reassembly under upstream stall: beats 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD(last) → up_trf_data=0xDDDD_CCCC_BBBB_AAAA. With up_trf_ready=0 for 5 cycles, dn_trf_ready=0 for those cycles and the word is held.
- Short frame: 2 beats with last on the 2nd → err_short pulses once, err_cnt=1, no up_trf_valid. The next good 4-beat frame is delivered correctly.
- Long frame plus reset: 6 beats with last on the 6th → word from beats 1–4 delivered, err_long pulses once, beats 5–6 dropped. Then assert rst mid-frame → err_cnt=0, the next good frame is delivered.
